// File: rtl/trace_capture_ila.sv
// In-fabric logic-analyzer capture core: circular sample buffer with pre-trigger depth,
// mask/value trigger, force-trigger, abort and a two-cycle readout port.
module trace_capture_ila #(
    parameter int C_WIDTH = 128,
    parameter int C_DEPTH = 1024,
    parameter int C_AW    = 10
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [C_WIDTH-1:0] TRIG0,
    input  logic               Arm,
    input  logic               Abort,
    input  logic               ForceTrig,
    input  logic [C_AW-1:0]    Pretrig,
    input  logic [C_WIDTH-1:0] TrigMask,
    input  logic [C_WIDTH-1:0] TrigValue,
    input  logic               RdEn,
    input  logic [C_AW-1:0]    RdAddr,
    output logic [2:0]         State,
    output logic               Done,
    output logic               TRIG_OUT,
    output logic [C_WIDTH-1:0] RdData,
    output logic               RdValid
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_WAIT    = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [C_AW-1:0]   r_wptr, r_cnt, r_pre, r_start, r_rd_addr;
    logic [C_AW-1:0]   w_cnt_next, w_pre_next, w_post;
    logic              r_trig_out, w_trig, w_writing, w_match;
    logic              w_rd_ok, w_squash, r_rd_v1, r_rd_valid;
    logic [C_WIDTH-1:0] r_rd_data;
    logic [C_WIDTH-1:0] r_mem [C_DEPTH];

    assign w_writing = (r_state == S_PREFILL) || (r_state == S_WAIT) || (r_state == S_POST);
    assign w_match   = (((TRIG0 ^ TrigValue) & TrigMask) == '0) || ForceTrig;
    // pre + trigger + post always totals C_DEPTH writes, so the buffer wraps exactly once.
    assign w_post    = {C_AW{1'b1}} - r_pre;
    assign w_rd_ok   = RdEn && (r_state == S_DONE) && !Abort && !Arm;
    assign w_squash  = Abort || Arm;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_pre_next = r_pre;
        w_trig     = 1'b0;
        if (Abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Arm) begin
                        w_pre_next = Pretrig;
                        w_cnt_next = Pretrig;
                        w_next     = (Pretrig == '0) ? S_WAIT : S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    w_cnt_next = r_cnt - C_AW'(1);
                    if (r_cnt == C_AW'(1)) w_next = S_WAIT;
                end
                S_WAIT: begin
                    if (w_match) begin
                        w_trig     = 1'b1;
                        w_cnt_next = w_post;
                        w_next     = (w_post == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    w_cnt_next = r_cnt - C_AW'(1);
                    if (r_cnt == C_AW'(1)) w_next = S_DONE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_cnt      <= '0;
            r_pre      <= '0;
            r_start    <= '0;
            r_trig_out <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_pre      <= w_pre_next;
            r_trig_out <= w_trig;
            if (w_writing) r_wptr <= r_wptr + C_AW'(1);
            // Entry to DONE always coincides with the last write, so the oldest sample is wptr+1.
            if (w_next == S_DONE && r_state != S_DONE) r_start <= r_wptr + C_AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_writing) r_mem[r_wptr] <= TRIG0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_addr  <= '0;
            r_rd_v1    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_v1    <= w_rd_ok;
            r_rd_valid <= r_rd_v1 && !w_squash;
            if (w_rd_ok) r_rd_addr <= r_start + RdAddr;
            if (r_rd_v1 && !w_squash) r_rd_data <= r_mem[r_rd_addr];
        end
    end

    assign State    = r_state;
    assign Done     = (r_state == S_DONE);
    assign TRIG_OUT = r_trig_out;
    assign RdData   = r_rd_data;
    assign RdValid  = r_rd_valid;

endmodule

// File: doc/trace_capture_ila.md
Name: trace_capture_ila

Overview:
- Parametrised in-fabric logic-analyzer capture core. It is the next generation of the black-box ILA probe, implemented in plain RTL, so no vendor core or JTAG control bus is needed.
- Records C_WIDTH-bit probe samples into a circular C_DEPTH-entry buffer.
- Supports a runtime pre-trigger depth, a mask/value trigger, force-trigger and abort.
- Exposes a post-capture readout port, used by SATA link/transport debug logic and a register bridge.

Parameters:
- C_WIDTH, 128, probe/sample width in bits.
- C_DEPTH, 1024, buffer depth in samples; power of two, >= 4.
- C_AW, 10, address width; must equal log2(C_DEPTH).

Ports:
- CLK  in  1  capture and readout clock.
- RST_N  in  1  asynchronous active-low reset.
- TRIG0  in  C_WIDTH  probe data, sampled every cycle while capturing.
- Arm  in  1  one-cycle start pulse.
- Abort  in  1  one-cycle cancel pulse.
- ForceTrig  in  1  unconditional trigger request.
- Pretrig  in  C_AW  number of samples to keep before the trigger; latched on Arm.
- TrigMask  in  C_WIDTH  compare mask; a bit set to 1 means that bit is compared.
- TrigValue  in  C_WIDTH  compare value.
- RdEn  in  1  readout request.
- RdAddr  in  C_AW  readout index; 0 = oldest sample.
- State  out  3  0 IDLE, 1 PREFILL, 2 WAIT, 3 POST, 4 DONE.
- Done  out  1  capture complete, buffer readable.
- TRIG_OUT  out  1  one-cycle pulse marking the trigger.
- RdData  out  C_WIDTH  readout sample.
- RdValid  out  1  RdData valid.

Behaviour:
- Reset: State=IDLE, Done=0, TRIG_OUT=0, RdValid=0, RdData=0, all pointers and counters 0. Buffer contents are not reset. Reset takes effect asynchronously at any point, including mid-capture.
- Arm, accepted only in IDLE or DONE:
  - latch pre = Pretrig; clear Done;
  - go to PREFILL, or directly to WAIT if pre==0.
  - Arm is ignored in PREFILL, WAIT and POST.
- Abort has priority over Arm. From any state it goes to IDLE and clears Done; buffer contents become undefined.
- Buffer writes:
  - In PREFILL, WAIT and POST, every cycle: mem[wptr] <= TRIG0, then wptr increments modulo C_DEPTH.
  - No writes in IDLE or DONE.
  - The first sample written is the TRIG0 value in the cycle after Arm.
- PREFILL:
  - Counts written samples; after the pre-th sample, go to WAIT.
  - Triggers, including ForceTrig, are ignored in this state.
- WAIT:
  - match = (((TRIG0 ^ TrigValue) & TrigMask) == 0) || ForceTrig. An all-zero TrigMask therefore matches on the first WAIT cycle.
  - The sample written in the matching cycle is the trigger sample.
  - On match, load post = C_DEPTH-1-pre. Go to POST, or directly to DONE if post==0.
  - WAIT may last any number of cycles; older samples are overwritten circularly.
- POST: writes post samples, then goes to DONE.
- Done = (State==DONE).
- TRIG_OUT is registered: high for exactly 1 cycle, in the cycle after the matching cycle.
- On entry to DONE, latch start = wptr (address of the oldest sample).
- Capture ordering:
  - Every capture holds exactly C_DEPTH samples, oldest first.
  - The trigger sample is at readout index pre.
  - This holds even when WAIT is shorter than C_DEPTH-pre, because PREFILL plus trigger plus POST always sum to C_DEPTH writes.
- Readout:
  - Readout is served only in DONE.
  - A RdEn in cycle N gives RdData = mem[(start+RdAddr) mod C_DEPTH] with RdValid=1 in cycle N+2: cycle 1 registers the address add, cycle 2 is the registered RAM read.
  - Back-to-back RdEn is supported, one result per cycle.
  - RdEn outside DONE: RdValid stays 0 and RdData holds its last value.
  - If Abort or Arm arrives with reads in flight, the in-flight reads are squashed (RdValid=0).
- Pretrig is clamped to C_DEPTH-1 by its width; its value outside Arm has no effect.
- The buffer maps to block RAM: one write port, one registered read port, no reset on the array.

Test Plan:
(All scenarios use C_WIDTH=16, C_DEPTH=16, C_AW=4, and TRIG0 = a free-running 16-bit counter.)
1. Arm when TRIG0=0x0030, Pretrig=4, TrigMask=0xFFFF, TrigValue=0x0040 -> State goes PREFILL, then WAIT. TRIG_OUT pulses the cycle after TRIG0=0x0040. Done is asserted after sample 0x004B. Reads of index 0..15 return 0x003C..0x004B, each with RdValid 2 cycles after RdEn.
2. Pretrig=0, TrigMask=0 -> trigger on the first sample (TRIG0 in the Arm+1 cycle), State skips PREFILL. Index 0 holds the trigger sample; indices 1..15 are consecutive.
3. Pretrig=15, match at 0x0040 -> POST is skipped; Done is asserted the cycle after the match. Index 15 = 0x0040 and index 0 = 0x0031.
4. ForceTrig held high from Arm with Pretrig=3 and a non-matching mask -> ignored during PREFILL; trigger on the first WAIT cycle, and index 3 holds that sample.
5. Abort during WAIT with Arm asserted in the same cycle -> IDLE, Done=0. A RdEn in IDLE gives RdValid=0. A subsequent Arm then completes a normal capture.
6. Assert RST_N low mid-POST and mid-readout -> all outputs go to 0 immediately, State=IDLE, TRIG_OUT never pulses again, and Arm after release works.
